// File: rtl/parking_gate_arbiter.sv
// Shares one barrier gate between entry and exit lanes, sequences the gate through gate_ack, tracks lot occupancy.
// Optional open-timeout forced close is enabled by defining GATE_ARB_TIMEOUT_EN.
module parking_gate_arbiter #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int OPEN_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             vehicle_passed,
  input  logic             gate_ack,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic             open_gate,
  output logic             close_gate,
  output logic [CNT_W-1:0] occupancy,
  output logic             lot_full,
  output logic             timeout_alarm
);

  typedef enum logic [1:0] {IDLE, OPENING, OPEN, CLOSING} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_ENTRY, OWN_EXIT} owner_t;

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  if (CAPACITY < 1 || CAPACITY >= (1 << CNT_W)) begin : g_bad_capacity
    $error("CAPACITY must be at least 1 and fit in CNT_W bits");
  end
  if (OPEN_TIMEOUT < 1) begin : g_bad_timeout
    $error("OPEN_TIMEOUT must be at least 1");
  end

  state_t           state_q, state_d;
  owner_t           owner_q, owner_d;
  logic             last_exit_q, last_exit_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             entry_ok;
  logic             expired;
  logic             timeout_fire;

`ifdef GATE_ARB_TIMEOUT_EN
  localparam int              TMR_W    = $clog2(OPEN_TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_TIMEOUT - 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             alarm_q, alarm_d;

  assign expired = (timer_q == TMR_LAST);

  always_comb begin
    timer_d = timer_q;
    alarm_d = timeout_fire;
    // Timer restarts as the gate reaches OPEN and stops at its terminal value.
    if (state_q == OPENING && gate_ack) begin
      timer_d = '0;
    end else if (state_q == OPEN && !expired) begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      alarm_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      alarm_q <= alarm_d;
    end
  end

  assign timeout_alarm = alarm_q;
`else
  assign expired       = 1'b0;
  assign timeout_alarm = 1'b0;
`endif

  assign lot_full = (occ_q == CAP);
  assign entry_ok = entry_req && !lot_full;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_exit_d  = last_exit_q;
    occ_d        = occ_q;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        // Contention goes to whichever lane was not served last.
        if (entry_ok && exit_req) begin
          owner_d = last_exit_q ? OWN_ENTRY : OWN_EXIT;
          state_d = OPENING;
        end else if (entry_ok) begin
          owner_d = OWN_ENTRY;
          state_d = OPENING;
        end else if (exit_req) begin
          owner_d = OWN_EXIT;
          state_d = OPENING;
        end
      end
      OPENING: begin
        if (gate_ack) state_d = OPEN;
      end
      OPEN: begin
        if (vehicle_passed) begin
          state_d = CLOSING;
          if (owner_q == OWN_ENTRY && occ_q < CAP) begin
            occ_d = occ_q + ONE;
          end else if (owner_q == OWN_EXIT && occ_q != '0) begin
            occ_d = occ_q - ONE;
          end
        end else if (expired) begin
          state_d      = CLOSING;
          timeout_fire = 1'b1;
        end
      end
      CLOSING: begin
        if (gate_ack) begin
          state_d     = IDLE;
          last_exit_d = (owner_q == OWN_EXIT);
          owner_d     = OWN_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      last_exit_q <= 1'b1;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_exit_q <= last_exit_d;
      occ_q       <= occ_d;
    end
  end

  assign entry_grant = (state_q == OPENING || state_q == OPEN) && owner_q == OWN_ENTRY;
  assign exit_grant  = (state_q == OPENING || state_q == OPEN) && owner_q == OWN_EXIT;
  assign open_gate   = (state_q == OPENING);
  assign close_gate  = (state_q == CLOSING);
  assign occupancy   = occ_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Scoreboard bench for parking_gate_arbiter: expected grants/occupancy queued at stimulus, compared at DUT output.
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst, entry_req, exit_req, vehicle_passed, gate_ack;
  logic       entry_grant, exit_grant, open_gate, close_gate, lot_full, timeout_alarm;
  logic [3:0] occupancy;

  int compared   = 0;
  int mismatched = 0;
  int model_occ  = 0;

  typedef struct {
    logic       entry;
    logic [3:0] occ;
  } exp_t;
  exp_t sb[$];

  parking_gate_arbiter #(.CAPACITY(8), .CNT_W(4), .OPEN_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
    .vehicle_passed(vehicle_passed), .gate_ack(gate_ack),
    .entry_grant(entry_grant), .exit_grant(exit_grant), .open_gate(open_gate),
    .close_gate(close_gate), .occupancy(occupancy), .lot_full(lot_full),
    .timeout_alarm(timeout_alarm)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag, input logic [3:0] exp_occ);
    compared++;
    if ({entry_grant, exit_grant, open_gate, close_gate, timeout_alarm} !== 5'b0) begin
      mismatched++;
      $display("FAIL %s_ctrl: got %b expected 00000", tag,
               {entry_grant, exit_grant, open_gate, close_gate, timeout_alarm});
    end
    compared++;
    if (occupancy !== exp_occ) begin
      mismatched++;
      $display("FAIL %s_occ: got %0d expected %0d", tag, occupancy, exp_occ);
    end
  endtask

  // One full transfer; the caller has already raised the request(s) and the DUT is in IDLE.
  task automatic serve(input logic exp_entry, input string tag);
    exp_t e;
    e.entry = exp_entry;
    if (exp_entry && model_occ < 8) model_occ++;
    else if (!exp_entry && model_occ > 0) model_occ--;
    e.occ = 4'(model_occ);
    sb.push_back(e);
    tick();
    e = sb.pop_front();
    compared++;
    if ({entry_grant, exit_grant, open_gate, close_gate} !== {e.entry, !e.entry, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL %s_grant: got eg/xg/og/cg=%b expected %b", tag,
               {entry_grant, exit_grant, open_gate, close_gate}, {e.entry, !e.entry, 2'b10});
    end
    if (exp_entry) entry_req = 1'b0; else exit_req = 1'b0;
    gate_ack = 1'b1;
    tick();
    gate_ack = 1'b0;
    compared++;
    if ({entry_grant, exit_grant, open_gate, close_gate} !== {e.entry, !e.entry, 2'b00}) begin
      mismatched++;
      $display("FAIL %s_open: got %b expected %b", tag,
               {entry_grant, exit_grant, open_gate, close_gate}, {e.entry, !e.entry, 2'b00});
    end
    vehicle_passed = 1'b1;
    tick();
    vehicle_passed = 1'b0;
    compared++;
    if ({entry_grant, exit_grant, open_gate, close_gate, timeout_alarm} !== 5'b00010 ||
        occupancy !== e.occ) begin
      mismatched++;
      $display("FAIL %s_closing: got ctrl=%b occ=%0d expected ctrl=00010 occ=%0d", tag,
               {entry_grant, exit_grant, open_gate, close_gate, timeout_alarm}, occupancy, e.occ);
    end
    gate_ack = 1'b1;
    tick();
    gate_ack = 1'b0;
    check_idle_outputs({tag, "_idle"}, e.occ);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_occ = 0;
  endtask

  task automatic test_reset();
    entry_req = 0; exit_req = 0; vehicle_passed = 0; gate_ack = 0;
    do_reset();
    check_idle_outputs("reset", 4'd0);
    compared++;
    if (lot_full !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_lot_full: got %b expected 0", lot_full);
    end
    // Stray ack and pass pulses in IDLE must not move anything.
    vehicle_passed = 1; gate_ack = 1;
    tick();
    vehicle_passed = 0; gate_ack = 0;
    tick();
    check_idle_outputs("idle_ignore", 4'd0);
  endtask

  task automatic test_single_entry();
    entry_req = 1;
    serve(1'b1, "single_entry");
  endtask

  task automatic test_round_robin();
    do_reset();
    entry_req = 1; exit_req = 1;
    serve(1'b1, "rr_first");
    serve(1'b0, "rr_second");
  endtask

  task automatic test_exit_empty();
    exit_req = 1;
    serve(1'b0, "exit_empty");
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      entry_req = 1;
      serve(1'b1, "fill");
    end
    entry_req = 1;
    for (int i = 0; i < 4; i++) tick();
    compared++;
    if ({lot_full, entry_grant, exit_grant, open_gate} !== 4'b1000 || occupancy !== 4'd8) begin
      mismatched++;
      $display("FAIL full_refuse: got full/eg/xg/og=%b occ=%0d expected 1000 occ=8",
               {lot_full, entry_grant, exit_grant, open_gate}, occupancy);
    end
    exit_req = 1;
    serve(1'b0, "full_exit");
    serve(1'b1, "full_reentry");
  endtask

  task automatic test_reset_in_open();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      entry_req = 1;
      serve(1'b1, "pre_fill");
    end
    entry_req = 1;
    tick();
    entry_req = 0;
    gate_ack = 1;
    tick();
    gate_ack = 0;
    compared++;
    if (entry_grant !== 1'b1 || occupancy !== 4'd3) begin
      mismatched++;
      $display("FAIL rst_open_pre: got eg=%b occ=%0d expected eg=1 occ=3", entry_grant, occupancy);
    end
    rst = 1;
    tick();
    rst = 0;
    model_occ = 0;
    check_idle_outputs("rst_open", 4'd0);
  endtask

  task automatic test_timeout();
    int n;
    entry_req = 1;
    tick();
    entry_req = 0;
    gate_ack = 1;
    tick();
    gate_ack = 0;
`ifdef GATE_ARB_TIMEOUT_EN
    n = 0;
    while (close_gate !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    compared++;
    if (n != 16 || timeout_alarm !== 1'b1 || occupancy !== 4'(model_occ)) begin
      mismatched++;
      $display("FAIL timeout_close: got cycles=%0d alarm=%b occ=%0d expected 16 1 %0d",
               n, timeout_alarm, occupancy, model_occ);
    end
    tick();
    compared++;
    if (timeout_alarm !== 1'b0 || close_gate !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_pulse: got alarm=%b cg=%b expected 0 1", timeout_alarm, close_gate);
    end
    gate_ack = 1;
    tick();
    gate_ack = 0;
    check_idle_outputs("timeout_idle", 4'(model_occ));
    // Vehicle pass on the same cycle the timer expires takes priority.
    entry_req = 1;
    tick();
    entry_req = 0;
    gate_ack = 1;
    tick();
    gate_ack = 0;
    for (int i = 0; i < 15; i++) tick();
    vehicle_passed = 1;
    tick();
    vehicle_passed = 0;
    model_occ++;
    compared++;
    if (close_gate !== 1'b1 || timeout_alarm !== 1'b0 || occupancy !== 4'(model_occ)) begin
      mismatched++;
      $display("FAIL pass_vs_timeout: got cg=%b alarm=%b occ=%0d expected 1 0 %0d",
               close_gate, timeout_alarm, occupancy, model_occ);
    end
    gate_ack = 1;
    tick();
    gate_ack = 0;
`else
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (entry_grant === 1'b1 && close_gate === 1'b0 && timeout_alarm === 1'b0) n++;
    end
    compared++;
    if (n != 40) begin
      mismatched++;
      $display("FAIL no_timeout_hold: got %0d open cycles expected 40", n);
    end
    vehicle_passed = 1;
    tick();
    vehicle_passed = 0;
    model_occ++;
    compared++;
    if (close_gate !== 1'b1 || occupancy !== 4'(model_occ)) begin
      mismatched++;
      $display("FAIL no_timeout_close: got cg=%b occ=%0d expected 1 %0d",
               close_gate, occupancy, model_occ);
    end
    gate_ack = 1;
    tick();
    gate_ack = 0;
`endif
    check_idle_outputs("timeout_end", 4'(model_occ));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; entry_req = 0; exit_req = 0; vehicle_passed = 0; gate_ack = 0;
    test_reset();
    test_single_entry();
    test_round_robin();
    test_exit_empty();
    test_full();
    test_reset_in_open();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
